// File: rtl/seg_digit_driver.sv
// Dual-digit seven-segment driver: synchronized digit select, dead-time between
// digits, registered nibble. Optional SEG_LEADING_ZERO_BLANK_EN hides a zero on digit 2.
module seg_digit_driver #(
  parameter int unsigned BLANK_CYCLES = 480,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  output logic [3:0] digit,
  output logic       an1,
  output logic       an2
);

  localparam int unsigned NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned CW = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam logic [CW-1:0] LAST = (BLANK_CYCLES == 0) ? '0 : CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {SHOW, BLANK, LOAD} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            cur_sel, cur_d;
  logic [3:0]      digit_d;
  logic            an1_d, an2_d;
  logic            rst_q;
  logic [NS-1:0]   sync_q;
  logic            sel_s;
  logic            suppress;

  // Asynchronous assert, release aligned to clk through one flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_q <= 1'b0;
    else        rst_q <= 1'b1;
  end

  assign sel_s = sync_q[NS-1];

  always_ff @(posedge clk or negedge rst_q) begin
    if (!rst_q) begin
      sync_q  <= '0;
      state   <= BLANK;
      cnt     <= '0;
      cur_sel <= 1'b0;
      digit   <= '0;
      an1     <= 1'b1;
      an2     <= 1'b1;
    end else begin
      sync_q  <= {sync_q[NS-2:0], sel};
      state   <= state_d;
      cnt     <= cnt_d;
      cur_sel <= cur_d;
      digit   <= digit_d;
      an1     <= an1_d;
      an2     <= an2_d;
    end
  end

  // Digit-2 suppression looks at the nibble already on the decoder, so a
  // 0 -> nonzero change lights the anode one cycle after digit updates.
`ifdef SEG_LEADING_ZERO_BLANK_EN
  assign suppress = (digit == 4'h0);
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cur_d   = cur_sel;
    digit_d = digit;
    unique case (state)
      SHOW: begin
        digit_d = cur_sel ? s2 : s1;
        if (sel_s != cur_sel) begin
          state_d = BLANK;
          cnt_d   = '0;
        end
      end
      BLANK: begin
        cnt_d = cnt + CW'(1);
        if (cnt == LAST) begin
          digit_d = sel_s ? s2 : s1;
          cur_d   = sel_s;
          state_d = LOAD;
        end
      end
      LOAD:    state_d = SHOW;
      default: state_d = BLANK;
    endcase
    // Anodes are registered from the next state so they switch on the same
    // edge as the state change.
    an1_d = !((state_d == SHOW) && !cur_d);
    an2_d = !((state_d == SHOW) && cur_d && !suppress);
  end

endmodule

// File: tb/tb_seg_digit_driver.sv
// Randomized self-checking bench for seg_digit_driver (BLANK_CYCLES 4 and 0)
// against a dark-interval countdown reference model.
module tb_seg_digit_driver;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] s1 = '0, s2 = '0;
  logic [3:0] digit4, digit0;
  logic       an1_4, an2_4, an1_0, an2_0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_digit_driver #(.BLANK_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sel(sel), .s1(s1), .s2(s2),
    .digit(digit4), .an1(an1_4), .an2(an2_4)
  );

  seg_digit_driver #(.BLANK_CYCLES(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset(reset), .sel(sel), .s1(s1), .s2(s2),
    .digit(digit0), .an1(an1_0), .an2(an2_0)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: index 0 = BLANK_CYCLES 4, index 1 = BLANK_CYCLES 0.
  // dark counts the remaining anode-off edges; the edge that brings it to 1
  // loads the new digit, reaching 0 shows it.
  logic       m_rel;
  logic [1:0] hist;
  int         m_dark [2];
  logic       m_cur  [2];
  logic [3:0] m_digit[2];
  logic       m_an1  [2];
  logic       m_an2  [2];

  function automatic int dark_len(input int i);
    int bc;
    bc = (i == 0) ? 4 : 0;
    return ((bc < 1) ? 1 : bc) + 1;
  endfunction

  task automatic model_reset();
    m_rel = 1'b0;
    hist  = '0;
    for (int i = 0; i < 2; i++) begin
      m_dark[i]  = dark_len(i);
      m_cur[i]   = 1'b0;
      m_digit[i] = '0;
      m_an1[i]   = 1'b1;
      m_an2[i]   = 1'b1;
    end
  endtask

  task automatic model_step();
    logic       ss;
    logic [3:0] dprev;
    logic       showing;
    if (!m_rel) begin
      m_rel = 1'b1;
      return;
    end
    ss = hist[1];
    for (int i = 0; i < 2; i++) begin
      dprev = m_digit[i];
      if (m_dark[i] == 0) begin
        m_digit[i] = m_cur[i] ? s2 : s1;
        if (ss != m_cur[i]) m_dark[i] = dark_len(i);
      end else begin
        m_dark[i]--;
        if (m_dark[i] == 1) begin
          m_digit[i] = ss ? s2 : s1;
          m_cur[i]   = ss;
        end
      end
      showing  = (m_dark[i] == 0);
      m_an1[i] = !(showing && !m_cur[i]);
      m_an2[i] = !(showing && m_cur[i] && !(LZ && dprev == 4'h0));
    end
    hist = {hist[0], sel};
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  task automatic tick();
    @(negedge clk);
    check("b4_digit", digit4, m_digit[0]);
    check("b4_an1",   an1_4,  m_an1[0]);
    check("b4_an2",   an2_4,  m_an2[0]);
    check("b0_digit", digit0, m_digit[1]);
    check("b0_an1",   an1_0,  m_an1[1]);
    check("b0_an2",   an2_0,  m_an2[1]);
    check("b4_excl",  int'(an1_4 | an2_4), 1);
    check("b0_excl",  int'(an1_0 | an2_0), 1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int first_a, first_b, first_c, off4, off0, ever;

    // Reset held with inputs active
    sel = 1'b1; s1 = 4'h3; s2 = 4'h7;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_an1", an1_4, 1);
      check("rst_an2", an2_4, 1);
      check("rst_digit", digit4, 0);
    end
    reset = 1'b1;
    first_a = -1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (first_a < 0 && an2_4 == 1'b0) begin
        first_a = t;
        check("rel_digit", digit4, 7);
      end
      check("rel_an1", an1_4, 1);
    end
    check("rel_latency", first_a, 6);

    // Switch digit 1 -> digit 2
    sel = 1'b0; s1 = 4'h5; s2 = 4'hA;
    ticks(20);
    check("d1_an1", an1_4, 0);
    check("d1_digit", digit4, 5);
    sel = 1'b1;
    first_a = -1; first_b = -1; first_c = -1; off4 = 0; off0 = 0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (first_a < 0 && an1_4) first_a = t;
      if (first_b < 0 && !an2_4) first_b = t;
      if (first_c < 0 && !an2_0) first_c = t;
      if (an1_4 && an2_4 && first_b < 0) off4++;
      if (an1_0 && an2_0 && first_c < 0) off0++;
      if (t == 7) check("preload_digit", digit4, 10);
    end
    check("an1_rise", first_a, 3);
    check("an2_fall", first_b, 8);
    check("dead4", off4, 5);
    check("an2_fall_bc0", first_c, 5);
    check("dead0", off0, 2);

    // Short select pulse during the dead-time
    sel = 1'b0;
    ticks(20);
    sel = 1'b1;
    tick(); tick();
    sel = 1'b0;
    first_a = -1; ever = 0;
    for (int t = 3; t <= 16; t++) begin
      tick();
      if (!an2_4) ever = 1;
      if (first_a < 0 && !an1_4 && t > 3) first_a = t;
    end
    check("pulse_no_an2", ever, 0);
    check("pulse_reshow", first_a, 8);

    // Value change while showing digit 2
    sel = 1'b1; s2 = 4'h2;
    ticks(20);
    s2 = 4'h9;
    tick();
    check("upd_digit", digit4, 9);
    check("upd_an2", an2_4, 0);
    check("upd_an1", an1_4, 1);

    // Zero on digit 2
    s2 = 4'h0;
    ticks(3);
    check("zero_digit", digit4, 0);
    check("zero_an2", an2_4, LZ ? 1 : 0);
    s2 = 4'h4;
    tick();
    check("nz_digit", digit4, 4);
    check("nz_an2_a", an2_4, LZ ? 1 : 0);
    tick();
    check("nz_an2_b", an2_4, 0);

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_an1", an1_4, 1);
    check("async_an2", an2_4, 1);
    check("async_digit", digit4, 0);
    ticks(2);
    reset = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      if ($urandom_range(11) == 0) sel = ~sel;
      if ($urandom_range(7) == 0) s1 = 4'($urandom);
      if ($urandom_range(7) == 0) s2 = ($urandom_range(2) == 0) ? 4'h0 : 4'($urandom);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(499) == 0) reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
